taillight_decoder: RTL and testbench
====================================

Name: taillight_decoder

Overview:
- Receive-side checker for the six-lamp turn-signal taillight interface (lc, lb, la, ra, rb, rc).
- Samples the lamp pattern on every clock and decodes the requested direction and sequence phase.
- Counts completed sweeps per side and flags any illegal lamp transition.
- Sits beside the taillight controller as a monitor, and drives dashboard indicators and a fault flag.

Parameters:
- CNT_W, 8, width of each saturating sweep counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- lc, lb, la  input  1 each  left lamps, outer to inner; sampled synchronously to clk.
- ra, rb, rc  input  1 each  right lamps, inner to outer; sampled synchronously to clk.
- clear  input  1  synchronous clear of counters and err_sticky.
- dir  output  2  00 idle, 01 left, 10 right, 11 unknown.
- phase  output  2  0 when idle/unknown; 1..3 = number of lamps lit in the current sweep.
- left_cnt  output  CNT_W  completed left sweeps, saturating.
- right_cnt  output  CNT_W  completed right sweeps, saturating.
- err  output  1  one-cycle pulse on an illegal transition.
- err_sticky  output  1  set by err; held until clear or reset.

Behaviour:
- Pattern notation: P = {lc,lb,la,ra,rb,rc}.
- Legal patterns:
  - Z = 000000
  - L1 = 001000, L2 = 011000, L3 = 111000
  - R1 = 000100, R2 = 000110, R3 = 000111
- States: IDLE, L1, L2, L3, R1, R2, R3, UNK. Each state is reflected directly in dir/phase (UNK gives dir=11, phase=0).
- The pattern must advance every clock. Legal next patterns:
  - IDLE: Z, L1, R1.
  - L1: L2, Z.
  - L2: L3, Z.
  - L3: L1, Z.
  - R1/R2/R3: mirror of the left side.
  - UNK: Z, L1, R1 leave UNK with no error; any other pattern stays in UNK with no error.
- Illegal transition, from any state except UNK:
  - err = 1 for exactly that cycle; err_sticky <= 1.
  - Resync: a legal pattern moves to its matching state; any other pattern (both sides lit, non-thermometer such as 101000) moves to UNK.
- Holding a nonzero pattern for two cycles is illegal.
- Counting: left_cnt increments on each entry to L3, right_cnt on each entry to R3. This includes L3/R3 entries reached by resync. Counters saturate at 2^CNT_W-1; no wrap.
- Latency: pattern sampled at edge k is reflected in all outputs immediately after edge k. All outputs are registered.
- clear = 1:
  - Counters go to 0 and err_sticky goes to 0 at the next edge.
  - If an error occurs on that same edge, err pulses and err_sticky ends at 1 (error wins).
  - If an L3/R3 entry occurs on that same edge, the counter ends at 0 (clear wins).
  - State, dir and phase are unaffected.
- Reset (reset = 0, asynchronous, may arrive mid-sweep): state = IDLE, dir = 00, phase = 0, counters = 0, err = 0, err_sticky = 0.
- First edge after reset release is checked from IDLE. For example, L2 on that edge is an error and resyncs to L2.

Test Plan:
- Reset low then high, P = Z for 3 cycles -> dir=00, phase=0, counters 0, err never 1.
- Sequence L1,L2,L3 repeated twice, then Z -> phase 1,2,3,1,2,3,0; dir=01 during the sweeps; left_cnt=2; err never 1.
- Sequence R1,R2,R3,Z -> dir=10, phase 1,2,3,0; right_cnt=1. Then apply L2 from IDLE -> err pulses once, err_sticky=1, dir=01, phase=2.
- Apply 001100 (both sides lit) -> err pulse, dir=11. Hold 001100 -> err stays 0, dir stays 11. Apply Z -> dir=00. Assert clear -> err_sticky=0.
- CNT_W=2, six left sweeps -> left_cnt reads 1,2,3,3,3,3. Drive clear on an edge entering L3 -> left_cnt=0.
- Drive reset low asynchronously mid-L2 (between edges) -> outputs go to reset values before the next edge. After release, L1 -> dir=01, phase=1, no err.

Source files
------------

// File: rtl/taillight_decoder.sv
// Receive-side monitor for the six-lamp turn-signal interface: decodes direction and
// sweep phase, counts completed sweeps per side and flags illegal lamp transitions.
module taillight_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lc,
  input  logic             lb,
  input  logic             la,
  input  logic             ra,
  input  logic             rb,
  input  logic             rc,
  input  logic             clear,
  output logic [1:0]       dir,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt,
  output logic             err,
  output logic             err_sticky
);

  typedef enum logic [2:0] {
    S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_UNK
  } state_t;

  state_t           state_q, state_d, pat_state;
  logic [1:0]       dir_q, dir_d, phase_q, phase_d;
  logic [CNT_W-1:0] left_cnt_q, left_cnt_d, right_cnt_q, right_cnt_d;
  logic             err_q, err_d, err_sticky_q, err_sticky_d;
  logic             legal;
  logic [5:0]       pat;

  assign pat = {lc, lb, la, ra, rb, rc};

  // NOTE: every signal written here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    pat_state = S_UNK;
    unique case (pat)
      6'b000000: pat_state = S_IDLE;
      6'b001000: pat_state = S_L1;
      6'b011000: pat_state = S_L2;
      6'b111000: pat_state = S_L3;
      6'b000100: pat_state = S_R1;
      6'b000110: pat_state = S_R2;
      6'b000111: pat_state = S_R3;
      default:   pat_state = S_UNK;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    unique case (state_q)
      S_IDLE:  legal = (pat_state == S_IDLE) || (pat_state == S_L1) || (pat_state == S_R1);
      S_L1:    legal = (pat_state == S_L2) || (pat_state == S_IDLE);
      S_L2:    legal = (pat_state == S_L3) || (pat_state == S_IDLE);
      S_L3:    legal = (pat_state == S_L1) || (pat_state == S_IDLE);
      S_R1:    legal = (pat_state == S_R2) || (pat_state == S_IDLE);
      S_R2:    legal = (pat_state == S_R3) || (pat_state == S_IDLE);
      S_R3:    legal = (pat_state == S_R1) || (pat_state == S_IDLE);
      default: legal = 1'b1;
    endcase
  end

  always_comb begin
    err_d   = 1'b0;
    state_d = pat_state;
    if (state_q == S_UNK) begin
      // Only a fresh start (Z, L1, R1) leaves UNK; anything else keeps waiting silently.
      if (!((pat_state == S_IDLE) || (pat_state == S_L1) || (pat_state == S_R1)))
        state_d = S_UNK;
    end else begin
      err_d = !legal;
    end

    dir_d   = 2'b00;
    phase_d = 2'b00;
    unique case (state_d)
      S_L1:    begin dir_d = 2'b01; phase_d = 2'd1; end
      S_L2:    begin dir_d = 2'b01; phase_d = 2'd2; end
      S_L3:    begin dir_d = 2'b01; phase_d = 2'd3; end
      S_R1:    begin dir_d = 2'b10; phase_d = 2'd1; end
      S_R2:    begin dir_d = 2'b10; phase_d = 2'd2; end
      S_R3:    begin dir_d = 2'b10; phase_d = 2'd3; end
      S_UNK:   begin dir_d = 2'b11; phase_d = 2'd0; end
      default: begin dir_d = 2'b00; phase_d = 2'd0; end
    endcase

    // Clear beats a same-edge count; the error pulse beats clear for the sticky flag.
    left_cnt_d  = left_cnt_q;
    right_cnt_d = right_cnt_q;
    if (clear) begin
      left_cnt_d  = '0;
      right_cnt_d = '0;
    end else begin
      if (state_d == S_L3 && state_q != S_L3 && left_cnt_q != '1)
        left_cnt_d = left_cnt_q + CNT_W'(1);
      if (state_d == S_R3 && state_q != S_R3 && right_cnt_q != '1)
        right_cnt_d = right_cnt_q + CNT_W'(1);
    end
    err_sticky_d = err_d || (err_sticky_q && !clear);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      dir_q        <= 2'b00;
      phase_q      <= 2'b00;
      left_cnt_q   <= '0;
      right_cnt_q  <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      phase_q      <= phase_d;
      left_cnt_q   <= left_cnt_d;
      right_cnt_q  <= right_cnt_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign dir        = dir_q;
  assign phase      = phase_q;
  assign left_cnt   = left_cnt_q;
  assign right_cnt  = right_cnt_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_taillight_decoder.sv
// Directed-vector bench for taillight_decoder: a default-width instance and a CNT_W=2
// instance share the same lamp stimulus.
module tb_taillight_decoder;

  localparam logic [5:0] PZ  = 6'b000000;
  localparam logic [5:0] PL1 = 6'b001000;
  localparam logic [5:0] PL2 = 6'b011000;
  localparam logic [5:0] PL3 = 6'b111000;
  localparam logic [5:0] PR1 = 6'b000100;
  localparam logic [5:0] PR2 = 6'b000110;
  localparam logic [5:0] PR3 = 6'b000111;
  localparam logic [5:0] PBOTH = 6'b001100;
  localparam logic [5:0] PGAP  = 6'b101000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lc = 0, lb = 0, la = 0, ra = 0, rb = 0, rc = 0;
  logic       clear = 1'b0;
  logic [1:0] dir, phase, dir_w2, phase_w2;
  logic [7:0] left_cnt, right_cnt;
  logic [1:0] left_cnt_w2, right_cnt_w2;
  logic       err, err_sticky, err_w2, err_sticky_w2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  taillight_decoder dut (
    .clk(clk), .reset(reset), .lc(lc), .lb(lb), .la(la), .ra(ra), .rb(rb), .rc(rc),
    .clear(clear), .dir(dir), .phase(phase), .left_cnt(left_cnt), .right_cnt(right_cnt),
    .err(err), .err_sticky(err_sticky)
  );

  taillight_decoder #(.CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .lc(lc), .lb(lb), .la(la), .ra(ra), .rb(rb), .rc(rc),
    .clear(clear), .dir(dir_w2), .phase(phase_w2), .left_cnt(left_cnt_w2),
    .right_cnt(right_cnt_w2), .err(err_w2), .err_sticky(err_sticky_w2)
  );

  // Drive one pattern, let one rising edge take it, then settle just past the edge.
  task automatic apply(input logic [5:0] p, input logic clr);
    {lc, lb, la, ra, rb, rc} = p;
    clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    {lc, lb, la, ra, rb, rc} = PZ;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(PZ, 1'b0);
      n_vec++;
      if (dir !== 2'b00 || phase !== 2'd0 || left_cnt !== 8'd0 || right_cnt !== 8'd0 ||
          err !== 1'b0 || err_sticky !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: dir=%0d phase=%0d lcnt=%0d rcnt=%0d err=%0b sticky=%0b, want all 0",
                 i, dir, phase, left_cnt, right_cnt, err, err_sticky);
      end
    end
  endtask

  task automatic test_left_sweep();
    logic [5:0] seq [7];
    logic [1:0] ph  [7];
    logic [1:0] exp_dir;
    seq = '{PL1, PL2, PL3, PL1, PL2, PL3, PZ};
    ph  = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 7; i++) begin
      apply(seq[i], 1'b0);
      exp_dir = (i < 6) ? 2'b01 : 2'b00;
      n_vec++;
      if (dir !== exp_dir || phase !== ph[i] || err !== 1'b0) begin
        n_bad++;
        $display("FAIL left_sweep[%0d]: dir=%0d phase=%0d err=%0b, want dir=%0d phase=%0d err=0",
                 i, dir, phase, err, exp_dir, ph[i]);
      end
    end
    n_vec++;
    if (left_cnt !== 8'd2 || left_cnt_w2 !== 2'd2 || err_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL left_count: lcnt=%0d lcnt_w2=%0d sticky=%0b, want 2 2 0",
               left_cnt, left_cnt_w2, err_sticky);
    end
  endtask

  task automatic test_right_and_resync();
    logic [5:0] seq [4];
    logic [1:0] ph  [4];
    logic [1:0] exp_dir;
    seq = '{PR1, PR2, PR3, PZ};
    ph  = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      apply(seq[i], 1'b0);
      exp_dir = (i < 3) ? 2'b10 : 2'b00;
      n_vec++;
      if (dir !== exp_dir || phase !== ph[i] || err !== 1'b0) begin
        n_bad++;
        $display("FAIL right_sweep[%0d]: dir=%0d phase=%0d err=%0b, want dir=%0d phase=%0d err=0",
                 i, dir, phase, err, exp_dir, ph[i]);
      end
    end
    n_vec++;
    if (right_cnt !== 8'd1 || left_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL right_count: rcnt=%0d lcnt=%0d, want 1 2", right_cnt, left_cnt);
    end
    apply(PL2, 1'b0);
    n_vec++;
    if (err !== 1'b1 || err_sticky !== 1'b1 || dir !== 2'b01 || phase !== 2'd2) begin
      n_bad++;
      $display("FAIL idle_to_l2: err=%0b sticky=%0b dir=%0d phase=%0d, want 1 1 1 2",
               err, err_sticky, dir, phase);
    end
    apply(PZ, 1'b0);
    n_vec++;
    if (err !== 1'b0 || err_sticky !== 1'b1 || dir !== 2'b00) begin
      n_bad++;
      $display("FAIL err_one_cycle: err=%0b sticky=%0b dir=%0d, want 0 1 0", err, err_sticky, dir);
    end
  endtask

  task automatic test_unknown();
    apply(PBOTH, 1'b0);
    n_vec++;
    if (err !== 1'b1 || dir !== 2'b11 || phase !== 2'd0) begin
      n_bad++;
      $display("FAIL both_sides: err=%0b dir=%0d phase=%0d, want 1 3 0", err, dir, phase);
    end
    apply(PBOTH, 1'b0);
    n_vec++;
    if (err !== 1'b0 || dir !== 2'b11) begin
      n_bad++;
      $display("FAIL unk_hold: err=%0b dir=%0d, want 0 3", err, dir);
    end
    apply(PZ, 1'b0);
    n_vec++;
    if (err !== 1'b0 || dir !== 2'b00 || err_sticky !== 1'b1) begin
      n_bad++;
      $display("FAIL unk_exit: err=%0b dir=%0d sticky=%0b, want 0 0 1", err, dir, err_sticky);
    end
    apply(PZ, 1'b1);
    n_vec++;
    if (err_sticky !== 1'b0 || left_cnt !== 8'd0 || right_cnt !== 8'd0 || dir !== 2'b00) begin
      n_bad++;
      $display("FAIL clear: sticky=%0b lcnt=%0d rcnt=%0d dir=%0d, want 0 0 0 0",
               err_sticky, left_cnt, right_cnt, dir);
    end
    apply(PGAP, 1'b0);
    n_vec++;
    if (err !== 1'b1 || dir !== 2'b11) begin
      n_bad++;
      $display("FAIL non_thermo: err=%0b dir=%0d, want 1 3", err, dir);
    end
    apply(PL2, 1'b0);
    n_vec++;
    if (err !== 1'b0 || dir !== 2'b11 || phase !== 2'd0) begin
      n_bad++;
      $display("FAIL unk_l2_stays: err=%0b dir=%0d phase=%0d, want 0 3 0", err, dir, phase);
    end
    apply(PL1, 1'b0);
    apply(PL2, 1'b0);
    apply(PL3, 1'b0);
    n_vec++;
    if (err !== 1'b0 || dir !== 2'b01 || phase !== 2'd3 || left_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL unk_restart: err=%0b dir=%0d phase=%0d lcnt=%0d, want 0 1 3 1",
               err, dir, phase, left_cnt);
    end
    apply(PZ, 1'b0);
    apply(PL2, 1'b1);
    n_vec++;
    if (err !== 1'b1 || err_sticky !== 1'b1 || left_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL clear_vs_err: err=%0b sticky=%0b lcnt=%0d, want 1 1 0",
               err, err_sticky, left_cnt);
    end
    apply(PZ, 1'b0);
  endtask

  task automatic test_saturation();
    logic [1:0] exp_w2;
    apply(PZ, 1'b1);
    n_vec++;
    if (err_sticky !== 1'b0 || left_cnt !== 8'd0 || left_cnt_w2 !== 2'd0) begin
      n_bad++;
      $display("FAIL sat_clear: sticky=%0b lcnt=%0d lcnt_w2=%0d, want 0 0 0",
               err_sticky, left_cnt, left_cnt_w2);
    end
    for (int s = 1; s <= 6; s++) begin
      apply(PL1, 1'b0);
      apply(PL2, 1'b0);
      apply(PL3, 1'b0);
      exp_w2 = (s < 3) ? s[1:0] : 2'd3;
      n_vec++;
      if (left_cnt_w2 !== exp_w2 || left_cnt !== s[7:0] || err !== 1'b0) begin
        n_bad++;
        $display("FAIL sat_sweep[%0d]: lcnt_w2=%0d lcnt=%0d err=%0b, want %0d %0d 0",
                 s, left_cnt_w2, left_cnt, err, exp_w2, s);
      end
    end
    apply(PL1, 1'b0);
    apply(PL2, 1'b0);
    apply(PL3, 1'b1);
    n_vec++;
    if (left_cnt !== 8'd0 || left_cnt_w2 !== 2'd0 || dir !== 2'b01 || phase !== 2'd3) begin
      n_bad++;
      $display("FAIL clear_vs_l3: lcnt=%0d lcnt_w2=%0d dir=%0d phase=%0d, want 0 0 1 3",
               left_cnt, left_cnt_w2, dir, phase);
    end
    for (int s = 0; s < 256; s++) begin
      apply(PL1, 1'b0);
      apply(PL2, 1'b0);
      apply(PL3, 1'b0);
      if (s == 254 || s == 255) begin
        n_vec++;
        if (left_cnt !== 8'd255 || left_cnt_w2 !== 2'd3 || err_sticky !== 1'b0) begin
          n_bad++;
          $display("FAIL sat_8bit[%0d]: lcnt=%0d lcnt_w2=%0d sticky=%0b, want 255 3 0",
                   s, left_cnt, left_cnt_w2, err_sticky);
        end
      end
    end
    apply(PZ, 1'b0);
  endtask

  task automatic test_async_reset();
    apply(PL1, 1'b0);
    apply(PL2, 1'b0);
    n_vec++;
    if (dir !== 2'b01 || phase !== 2'd2) begin
      n_bad++;
      $display("FAIL pre_reset_l2: dir=%0d phase=%0d, want 1 2", dir, phase);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (dir !== 2'b00 || phase !== 2'd0 || left_cnt !== 8'd0 || left_cnt_w2 !== 2'd0 ||
        err !== 1'b0 || err_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: dir=%0d phase=%0d lcnt=%0d lcnt_w2=%0d err=%0b sticky=%0b, want all 0",
               dir, phase, left_cnt, left_cnt_w2, err, err_sticky);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    apply(PL1, 1'b0);
    n_vec++;
    if (dir !== 2'b01 || phase !== 2'd1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_l1: dir=%0d phase=%0d err=%0b, want 1 1 0", dir, phase, err);
    end
    apply(PL2, 1'b0);
    #2 reset = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    apply(PL2, 1'b0);
    n_vec++;
    if (err !== 1'b1 || err_sticky !== 1'b1 || dir !== 2'b01 || phase !== 2'd2) begin
      n_bad++;
      $display("FAIL post_reset_l2: err=%0b sticky=%0b dir=%0d phase=%0d, want 1 1 1 2",
               err, err_sticky, dir, phase);
    end
  endtask

  initial begin
    test_reset();
    test_left_sweep();
    test_right_and_resync();
    test_unknown();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
